// File: rtl/config_loader.sv
// Configuration loader: streams NUM_WORDS words into level-sensitive latch banks with a
// setup/strobe/hold sequence per word. Optional trailing checksum word enabled by CFG_CHECKSUM_EN.
module config_loader #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WORD_W-1:0]    io_in_data,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_done,
  output logic                 io_err
);

  localparam int unsigned       IdxW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IdxW-1:0]   LastIdx = IdxW'(NUM_WORDS - 1);
  localparam logic [NUM_WORDS-1:0] EnOne = NUM_WORDS'(1);

`ifdef CFG_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StSetup, StStrobe, StHold, StCheck, StDone
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StSetup, StStrobe, StHold, StDone
  } state_e;
`endif

  state_e                 state_q;
  logic [IdxW-1:0]        idx_q;
  logic [WORD_W-1:0]      d_out_q;
  logic [NUM_WORDS-1:0]   en_q;
  logic                   done_q;

`ifdef CFG_CHECKSUM_EN
  logic [WORD_W-1:0]      csum_q;
  logic                   err_q;

  assign io_in_ready = ((state_q == StIdle) || (state_q == StCheck)) && !io_start;
  assign io_err      = err_q;
`else
  assign io_in_ready = (state_q == StIdle) && !io_start;
  assign io_err      = 1'b0;
`endif

  assign io_d_out      = d_out_q;
  assign io_configs_en = en_q;
  assign io_done       = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      d_out_q <= '0;
      en_q    <= '0;
      done_q  <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else if (io_start) begin
      // Abort: in-flight word is dropped, d_out is left alone since no enable is high.
      state_q <= StIdle;
      idx_q   <= '0;
      en_q    <= '0;
      done_q  <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (io_in_valid) begin
            d_out_q <= io_in_data;
`ifdef CFG_CHECKSUM_EN
            csum_q  <= csum_q ^ io_in_data;
`endif
            state_q <= StSetup;
          end
        end
        StSetup: begin
          en_q    <= EnOne << idx_q;
          state_q <= StStrobe;
        end
        StStrobe: begin
          en_q    <= '0;
          state_q <= StHold;
        end
        StHold: begin
          if (idx_q != LastIdx) begin
            idx_q   <= idx_q + 1'b1;
            state_q <= StIdle;
          end else begin
`ifdef CFG_CHECKSUM_EN
            state_q <= StCheck;
`else
            state_q <= StDone;
            done_q  <= 1'b1;
`endif
          end
        end
`ifdef CFG_CHECKSUM_EN
        StCheck: begin
          // Trailing word is compared, never strobed into a bank.
          if (io_in_valid) begin
            err_q   <= (io_in_data != csum_q);
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
`endif
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: randomized stimulus against a timing model expressed
// as word count plus cycles since the last accept. Checksum scenario runs when CFG_CHECKSUM_EN is set.
module tb_config_loader;

  localparam int unsigned W = 32;
  localparam int unsigned N = 17;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         io_start = 1'b0;
  logic         io_in_valid = 1'b0;
  logic         io_in_ready;
  logic [W-1:0] io_in_data = '0;
  logic [W-1:0] io_d_out;
  logic [N-1:0] io_configs_en;
  logic         io_done;
  logic         io_err;

  config_loader #(
    .WORD_W    (W),
    .NUM_WORDS (N)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (io_start),
    .io_in_valid   (io_in_valid),
    .io_in_ready   (io_in_ready),
    .io_in_data    (io_in_data),
    .io_d_out      (io_d_out),
    .io_configs_en (io_configs_en),
    .io_done       (io_done),
    .io_err        (io_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: words accepted so far, and cycles elapsed since the last accept (1=setup,2=strobe,3=hold).
  int           m_k;
  int           m_age;
  logic [W-1:0] m_dout;
  logic [W-1:0] m_csum;
  bit           m_checked;
  bit           m_err;

  logic         exp_ready;
  logic [N-1:0] exp_en;
  logic         exp_done;
  logic         exp_err;
  bit           exp_dout_chk;

  task automatic model_reset();
    m_k = 0; m_age = 4; m_dout = '0; m_csum = '0; m_checked = 0; m_err = 0;
  endtask

  task automatic model_expect();
    bit free;
    free = (m_k == 0) || (m_age >= 4);
    exp_en = '0;
    if (m_k > 0 && m_age == 2) exp_en[m_k-1] = 1'b1;
    exp_dout_chk = (m_k > 0) && (m_age >= 1) && (m_age <= 3);
`ifdef CFG_CHECKSUM_EN
    exp_ready = !io_start && free && ((m_k < N) || !m_checked);
    exp_done  = m_checked;
    exp_err   = m_err;
`else
    exp_ready = !io_start && free && (m_k < N);
    exp_done  = free && (m_k == N);
    exp_err   = 1'b0;
`endif
  endtask

  task automatic model_advance();
    if (io_start) begin
      model_reset();
    end else if (exp_ready && io_in_valid) begin
      if (m_k < N) begin
        m_k++; m_age = 1; m_dout = io_in_data; m_csum ^= io_in_data;
      end else begin
        m_checked = 1; m_err = (io_in_data != m_csum);
      end
    end else if (m_age < 100) begin
      m_age++;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_expect();
  endtask

  task automatic adv();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; io_start = 1'b0; io_in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; io_start = 1'b1; io_in_valid = 1'b1; io_in_data = $urandom;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; io_start = 1'b0; io_in_valid = 1'b0;
    model_reset();
    sample();
    n_cmp++; if (io_configs_en !== '0) begin n_bad++;
      $display("FAIL reset_en got %h want 0", io_configs_en); end
    n_cmp++; if (io_d_out !== '0) begin n_bad++;
      $display("FAIL reset_dout got %h want 0", io_d_out); end
    n_cmp++; if ({io_done, io_err} !== 2'b00) begin n_bad++;
      $display("FAIL reset_done_err got %b want 00", {io_done, io_err}); end
    n_cmp++; if (io_in_ready !== exp_ready) begin n_bad++;
      $display("FAIL reset_ready got %b want %b", io_in_ready, exp_ready); end
    adv();
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int want_acc;
    do_reset();
    io_in_valid = 1'b1;
    for (int c = 0; c < 120; c++) begin
      io_in_data = 32'h1000_0000 + W'(m_k);
      sample();
      n_cmp++; if (io_in_ready !== exp_ready) begin n_bad++;
        $display("FAIL b2b_ready c=%0d got %b want %b", c, io_in_ready, exp_ready); end
      n_cmp++; if (io_configs_en !== exp_en) begin n_bad++;
        $display("FAIL b2b_en c=%0d got %h want %h", c, io_configs_en, exp_en); end
      if (exp_en != '0) begin
        n_cmp++; if (io_d_out !== 32'h1000_0000 + W'(m_k - 1)) begin n_bad++;
          $display("FAIL b2b_dout c=%0d got %h want %h", c, io_d_out,
                   32'h1000_0000 + W'(m_k - 1)); end
      end
      n_cmp++; if (io_done !== exp_done) begin n_bad++;
        $display("FAIL b2b_done c=%0d got %b want %b", c, io_done, exp_done); end
      if (io_in_valid && io_in_ready) acc++;
      adv();
    end
`ifdef CFG_CHECKSUM_EN
    want_acc = N + 1;
`else
    want_acc = N;
`endif
    n_cmp++; if (acc != want_acc) begin n_bad++;
      $display("FAIL b2b_accepts got %0d want %0d", acc, want_acc); end
    n_cmp++; if (io_done !== 1'b1) begin n_bad++;
      $display("FAIL b2b_final_done got %b want 1", io_done); end
    io_in_valid = 1'b0;
  endtask

  task automatic test_start_strobe();
    bit hit = 0;
    bit seen_en = 0;
    do_reset();
    io_in_valid = 1'b1;
    for (int c = 0; c < 60 && !hit; c++) begin
      io_start = (m_k == 6 && m_age == 2);
      io_in_data = $urandom;
      sample();
      if (io_start) begin
        hit = 1;
        n_cmp++; if (io_configs_en !== exp_en) begin n_bad++;
          $display("FAIL abort_strobe_en got %h want %h", io_configs_en, exp_en); end
        n_cmp++; if (io_in_ready !== 1'b0) begin n_bad++;
          $display("FAIL abort_ready got %b want 0", io_in_ready); end
      end
      adv();
    end
    n_cmp++; if (!hit) begin n_bad++;
      $display("FAIL abort_reach got strobe_of_word5=0 want 1"); end
    io_start = 1'b0;
    io_in_valid = 1'b0;
    sample();
    n_cmp++; if (io_configs_en !== '0) begin n_bad++;
      $display("FAIL abort_en_drop got %h want 0", io_configs_en); end
    n_cmp++; if (io_in_ready !== exp_ready) begin n_bad++;
      $display("FAIL abort_idle_ready got %b want %b", io_in_ready, exp_ready); end
    adv();
    io_in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      io_in_data = $urandom;
      sample();
      n_cmp++; if (io_configs_en !== exp_en) begin n_bad++;
        $display("FAIL restart_en c=%0d got %h want %h", c, io_configs_en, exp_en); end
      if (io_configs_en != '0 && !seen_en) begin
        seen_en = 1;
        n_cmp++; if (io_configs_en !== 17'h1) begin n_bad++;
          $display("FAIL restart_first_bank got %h want 00001", io_configs_en); end
      end
      adv();
    end
    io_in_valid = 1'b0;
  endtask

  task automatic test_start_valid();
    do_reset();
    io_start = 1'b1; io_in_valid = 1'b1; io_in_data = $urandom;
    sample();
    n_cmp++; if (io_in_ready !== 1'b0) begin n_bad++;
      $display("FAIL start_valid_ready got %b want 0", io_in_ready); end
    adv();
    io_start = 1'b0; io_in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      n_cmp++; if (io_configs_en !== exp_en) begin n_bad++;
        $display("FAIL start_valid_en c=%0d got %h want %h", c, io_configs_en, exp_en); end
      n_cmp++; if (io_in_ready !== exp_ready) begin n_bad++;
        $display("FAIL start_valid_idle c=%0d got %b want %b", c, io_in_ready, exp_ready); end
      adv();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      io_start    = ($urandom_range(0, 29) == 0);
      io_in_valid = ($urandom_range(0, 1) == 1);
      io_in_data  = (m_k == N && $urandom_range(0, 1) == 1) ? m_csum : $urandom;
      sample();
      n_cmp++; if (io_in_ready !== exp_ready) begin n_bad++;
        $display("FAIL rnd_ready c=%0d got %b want %b", c, io_in_ready, exp_ready); end
      n_cmp++; if (io_configs_en !== exp_en) begin n_bad++;
        $display("FAIL rnd_en c=%0d got %h want %h", c, io_configs_en, exp_en); end
      n_cmp++; if ({io_done, io_err} !== {exp_done, exp_err}) begin n_bad++;
        $display("FAIL rnd_done_err c=%0d got %b want %b", c, {io_done, io_err},
                 {exp_done, exp_err}); end
      if (exp_dout_chk) begin
        n_cmp++; if (io_d_out !== m_dout) begin n_bad++;
          $display("FAIL rnd_dout c=%0d got %h want %h", c, io_d_out, m_dout); end
      end
      n_cmp++; if ($countones(io_configs_en) > 1) begin n_bad++;
        $display("FAIL rnd_onehot c=%0d got %h want at most one bit", c, io_configs_en); end
      adv();
    end
    io_start = 1'b0; io_in_valid = 1'b0;
  endtask

  task automatic test_reset_midload();
    bit hit = 0;
    do_reset();
    io_in_valid = 1'b1;
    for (int c = 0; c < 40 && !hit; c++) begin
      io_in_data = $urandom;
      if (m_k == 3 && m_age == 2) begin
        hit = 1;
        reset = 1'b1;
        sample();
        n_cmp++; if (io_configs_en !== exp_en) begin n_bad++;
          $display("FAIL midrst_strobe got %h want %h", io_configs_en, exp_en); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        io_in_valid = 1'b0;
        model_reset();
      end else begin
        sample();
        adv();
      end
    end
    n_cmp++; if (!hit) begin n_bad++;
      $display("FAIL midrst_reach got strobe_seen=0 want 1"); end
    sample();
    n_cmp++; if ({io_configs_en, io_d_out, io_done, io_err} !== '0) begin n_bad++;
      $display("FAIL midrst_outputs got en=%h dout=%h done=%b err=%b want all 0",
               io_configs_en, io_d_out, io_done, io_err); end
    n_cmp++; if (io_in_ready !== exp_ready) begin n_bad++;
      $display("FAIL midrst_ready got %b want %b", io_in_ready, exp_ready); end
    adv();
  endtask

`ifdef CFG_CHECKSUM_EN
  task automatic test_checksum();
    logic [W-1:0] chk_word;
    for (int pass = 0; pass < 2; pass++) begin
      chk_word = (pass == 0) ? 32'h1 : 32'h0;
      do_reset();
      io_in_valid = 1'b1;
      for (int c = 0; c < 100 && !m_checked; c++) begin
        io_in_data = (m_k < N) ? 32'h1 : chk_word;
        sample();
        n_cmp++; if (io_configs_en !== exp_en) begin n_bad++;
          $display("FAIL csum_en p=%0d c=%0d got %h want %h", pass, c, io_configs_en, exp_en); end
        adv();
      end
      io_in_valid = 1'b0;
      sample();
      n_cmp++; if (io_done !== 1'b1) begin n_bad++;
        $display("FAIL csum_done p=%0d got %b want 1", pass, io_done); end
      n_cmp++; if (io_err !== (pass == 1)) begin n_bad++;
        $display("FAIL csum_err p=%0d got %b want %b", pass, io_err, (pass == 1)); end
      n_cmp++; if (io_in_ready !== 1'b0) begin n_bad++;
        $display("FAIL csum_ready_done p=%0d got %b want 0", pass, io_in_ready); end
      adv();
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_back_to_back();
    test_start_strobe();
    test_start_valid();
    test_random();
    test_reset_midload();
`ifdef CFG_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
